// File: rtl/bw_rmw_pkg.sv
// Shared types and the bit-merge helper for the bit-write emulation stage.
package bw_rmw_pkg;

  localparam int ROW_W = 132;
  localparam int ADR_W = 8;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [ADR_W-1:0] addr;
    logic [ROW_W-1:0] bw;
    logic [ROW_W-1:0] din;
  } op_t;

  function automatic logic [ROW_W-1:0] merge_row(input logic [ROW_W-1:0] base,
                                                 input logic [ROW_W-1:0] din,
                                                 input logic [ROW_W-1:0] bw);
    return (base & ~bw) | (din & bw);
  endfunction

endpackage

// File: rtl/bw_rmw_hist.sv
// History of the last DEPTH physical writes, newest at index 0, with an
// address lookup that returns the newest matching row.
module bw_rmw_hist
  import bw_rmw_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ROWWDTH = ROW_W,
  parameter int BITSROW = ADR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_vld,
  input  logic [BITSROW-1:0] push_adr,
  input  logic [ROWWDTH-1:0] push_row,
  input  logic [BITSROW-1:0] lk_adr,
  output logic               hit,
  output logic [ROWWDTH-1:0] row
);

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [BITSROW-1:0] adr_q [DEPTH];
  logic [BITSROW-1:0] adr_d [DEPTH];
  logic [ROWWDTH-1:0] row_q [DEPTH];
  logic [ROWWDTH-1:0] row_d [DEPTH];

  always_comb begin
    vld_d[0] = push_vld;
    adr_d[0] = push_adr;
    row_d[0] = push_row;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      adr_d[i] = adr_q[i-1];
      row_d[i] = row_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      adr_q[i] <= adr_d[i];
      row_q[i] <= row_d[i];
    end
  end

  // Scan oldest to newest so the newest match wins.
  always_comb begin
    hit = 1'b0;
    row = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && (adr_q[i] == lk_adr)) begin
        hit = 1'b1;
        row = row_q[i];
      end
    end
  end

endmodule

// File: rtl/bw_rmw.sv
// Emulates a bit-writable SRAM on a 1R1W macro: read, merge, write back
// SRAM_DELAY cycles later, forwarding from writes the read could not see.
module bw_rmw
  import bw_rmw_pkg::*;
#(
  parameter int ROWWDTH    = ROW_W,
  parameter int NUMSROW    = 256,
  parameter int BITSROW    = ADR_W,
  parameter int SRAM_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [BITSROW-1:0] mem_addr,
  input  logic [ROWWDTH-1:0] mem_bw,
  input  logic [ROWWDTH-1:0] mem_din,
  output logic [ROWWDTH-1:0] mem_dout,
  output logic               prd,
  output logic [BITSROW-1:0] prdadr,
  input  logic [ROWWDTH-1:0] prdout,
  output logic               pwr,
  output logic [BITSROW-1:0] pwradr,
  output logic [ROWWDTH-1:0] pwrdin
);

  if (SRAM_DELAY < 1 || NUMSROW > (1 << BITSROW)) begin : g_bad_cfg
    $error("bw_rmw: illegal SRAM_DELAY/NUMSROW/BITSROW combination");
  end

  op_t in_op, done_op;

  logic [SRAM_DELAY-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [BITSROW-1:0]    adr_q [SRAM_DELAY];
  logic [BITSROW-1:0]    adr_d [SRAM_DELAY];
  logic [ROWWDTH-1:0]    bw_q  [SRAM_DELAY];
  logic [ROWWDTH-1:0]    bw_d  [SRAM_DELAY];
  logic [ROWWDTH-1:0]    din_q [SRAM_DELAY];
  logic [ROWWDTH-1:0]    din_d [SRAM_DELAY];

  logic               hist_hit;
  logic [ROWWDTH-1:0] hist_row, base_row, merged_row;

  always_comb begin
    in_op.rd   = mem_read  & ~rst;
    in_op.wr   = mem_write & ~rst;
    in_op.addr = mem_addr;
    in_op.bw   = mem_bw;
    in_op.din  = mem_din;

    rd_d[0]  = in_op.rd;
    wr_d[0]  = in_op.wr;
    adr_d[0] = in_op.addr;
    bw_d[0]  = in_op.bw;
    din_d[0] = in_op.din;
    for (int i = 1; i < SRAM_DELAY; i++) begin
      rd_d[i]  = rd_q[i-1];
      wr_d[i]  = wr_q[i-1];
      adr_d[i] = adr_q[i-1];
      bw_d[i]  = bw_q[i-1];
      din_d[i] = din_q[i-1];
    end
  end

  assign prd    = in_op.rd | in_op.wr;
  assign prdadr = rst ? '0 : mem_addr;

  // Op pipeline: only the valids are reset, payload just follows along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SRAM_DELAY; i++) begin
      adr_q[i] <= adr_d[i];
      bw_q[i]  <= bw_d[i];
      din_q[i] <= din_d[i];
    end
  end

  always_comb begin
    done_op.rd   = rd_q[SRAM_DELAY-1];
    done_op.wr   = wr_q[SRAM_DELAY-1];
    done_op.addr = adr_q[SRAM_DELAY-1];
    done_op.bw   = bw_q[SRAM_DELAY-1];
    done_op.din  = din_q[SRAM_DELAY-1];
  end

  bw_rmw_hist #(
    .DEPTH  (SRAM_DELAY),
    .ROWWDTH(ROWWDTH),
    .BITSROW(BITSROW)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .push_vld(done_op.wr),
    .push_adr(done_op.addr),
    .push_row(merged_row),
    .lk_adr  (done_op.addr),
    .hit     (hist_hit),
    .row     (hist_row)
  );

  // Completion stage: the macro's row is stale if a newer write is in history.
  always_comb begin
    base_row   = hist_hit ? hist_row : prdout;
    merged_row = merge_row(base_row, done_op.din, done_op.bw);
    mem_dout   = done_op.rd ? base_row : '0;
    pwr        = done_op.wr;
    pwradr     = done_op.wr ? done_op.addr : '0;
    pwrdin     = done_op.wr ? merged_row : '0;
  end

endmodule

// File: tb/tb_bw_rmw.sv
// Bench for bw_rmw: behavioural 1R1W macro, native-SRAM reference model and
// a completion scoreboard, plus a table of forwarding vectors.
module tb_bw_rmw;

  localparam int W = 132;
  localparam int A = 8;
  localparam int D = 2;

  logic         clk, rst;
  logic         mem_read, mem_write;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_bw, mem_din, mem_dout;
  logic         prd, pwr;
  logic [A-1:0] prdadr, pwradr;
  logic [W-1:0] prdout, pwrdin;

  bw_rmw #(.ROWWDTH(W), .NUMSROW(256), .BITSROW(A), .SRAM_DELAY(D)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_bw(mem_bw), .mem_din(mem_din), .mem_dout(mem_dout),
    .prd(prd), .prdadr(prdadr), .prdout(prdout),
    .pwr(pwr), .pwradr(pwradr), .pwrdin(pwrdin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1R1W macro, read-old on a same-cycle write.
  logic [W-1:0] smem     [256];
  logic [W-1:0] init_mem [256];
  logic [W-1:0] rpipe    [D];
  logic         load;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) smem[i] <= init_mem[i];
    end else if (pwr) begin
      smem[pwradr] <= pwrdin;
    end
    if (prd) rpipe[0] <= smem[prdadr];
    for (int i = 1; i < D; i++) rpipe[i] <= rpipe[i-1];
  end
  assign prdout = rpipe[D-1];

  typedef struct {
    int           due;
    logic         rd;
    logic         wr;
    logic [A-1:0] addr;
    logic [W-1:0] exp_dout;
    logic [W-1:0] exp_row;
  } exp_t;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [A-1:0] addr;
    logic [W-1:0] bw;
    logic [W-1:0] din;
    logic [W-1:0] exp_row;
  } vec_t;

  exp_t         sb[$];
  logic [W-1:0] ref_mem [256];
  int           cyc;
  int           n_tests;
  int           n_fail;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_done();
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("pwr", W'(pwr), W'(e.wr));
      chk("mem_dout", mem_dout, e.rd ? e.exp_dout : '0);
      if (e.wr) begin
        chk("pwradr", W'(pwradr), W'(e.addr));
        chk("pwrdin", pwrdin, e.exp_row);
      end
    end else begin
      chk("pwr_idle", W'(pwr), '0);
      chk("dout_idle", mem_dout, '0);
    end
  endtask

  // One upstream cycle; the scoreboard expects the completion D cycles later.
  task automatic do_op(input logic rd, input logic wr, input logic [A-1:0] a,
                       input logic [W-1:0] bw, input logic [W-1:0] din,
                       input logic use_tab, input logic [W-1:0] tab_row);
    exp_t         e;
    logic [W-1:0] m;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_bw    = bw;
    mem_din   = din;
    if (rd || wr) begin
      m = (ref_mem[a] & ~bw) | (din & bw);
      if (use_tab) m = tab_row;
      e.due      = cyc + D;
      e.rd       = rd;
      e.wr       = wr;
      e.addr     = a;
      e.exp_dout = ref_mem[a];
      e.exp_row  = m;
      if (wr) ref_mem[a] = m;
      sb.push_back(e);
    end
    #5;
    chk("prd", W'(prd), W'(rd | wr));
    if (rd || wr) chk("prdadr", W'(prdadr), W'(a));
    check_done();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_op(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  vec_t         tab [3];
  logic [W-1:0] saved, ones;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    ones    = '1;
    rst = 1'b1; load = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_bw = '0; mem_din = '0;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = rnd_row();
      if (i == 3) init_mem[i] = '0;
      ref_mem[i] = init_mem[i];
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    load = 1'b0;

    // Reset state, with upstream requests held active.
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 8'h55; mem_bw = ones; mem_din = ones;
    #2;
    chk("rst_prd", W'(prd), '0);
    chk("rst_prdadr", W'(prdadr), '0);
    chk("rst_pwr", W'(pwr), '0);
    chk("rst_pwradr", W'(pwradr), '0);
    chk("rst_pwrdin", pwrdin, '0);
    chk("rst_dout", mem_dout, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;

    // Low-byte write then a later read of the same row.
    do_op(1'b0, 1'b1, 8'd5, W'(8'hFF), ones, 1'b0, '0);
    idle(4);
    do_op(1'b1, 1'b0, 8'd5, '0, '0, 1'b0, '0);
    idle(3);

    // Forwarding at distances 1 and 2 on a zero row.
    tab[0] = '{1'b0, 1'b1, 8'd3, W'(1), ones, W'(1)};
    tab[1] = '{1'b0, 1'b1, 8'd3, W'(2), ones, W'(3)};
    tab[2] = '{1'b0, 1'b1, 8'd3, W'(4), ones, W'(7)};
    for (int i = 0; i < 3; i++)
      do_op(tab[i].rd, tab[i].wr, tab[i].addr, tab[i].bw, tab[i].din, 1'b1, tab[i].exp_row);
    idle(3);

    // Read+write together, then reads one and two cycles behind the write.
    do_op(1'b1, 1'b1, 8'd7, rnd_row(), rnd_row(), 1'b0, '0);
    do_op(1'b1, 1'b0, 8'd7, '0, '0, 1'b0, '0);
    do_op(1'b1, 1'b0, 8'd7, '0, '0, 1'b0, '0);
    idle(3);

    // Back-to-back alternating writes at full rate.
    for (int i = 0; i < 20; i++)
      do_op(1'b0, 1'b1, (i % 2 == 0) ? 8'd1 : 8'd2, rnd_row(), rnd_row(), 1'b0, '0);
    idle(3);
    chk("macro_row1", smem[1], ref_mem[1]);
    chk("macro_row2", smem[2], ref_mem[2]);

    // Zero-mask write rewrites the row unchanged.
    do_op(1'b0, 1'b1, 8'd9, '0, rnd_row(), 1'b0, '0);
    idle(3);
    chk("macro_row9", smem[9], init_mem[9]);

    // Reset one cycle after a write: the write must never reach the macro.
    saved = ref_mem[11];
    mem_read = 1'b0; mem_write = 1'b1; mem_addr = 8'd11; mem_bw = ones; mem_din = ~saved;
    #5;
    check_done();
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0;
    #4;
    chk("mid_rst_prd", W'(prd), '0);
    chk("mid_rst_pwr", W'(pwr), '0);
    chk("mid_rst_pwrdin", pwrdin, '0);
    chk("mid_rst_dout", mem_dout, '0);
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    mem_read = 1'b0;
    idle(3);
    do_op(1'b1, 1'b0, 8'd11, '0, '0, 1'b0, '0);
    idle(3);
    chk("macro_row11", smem[11], saved);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bw_rmw.md
# bw_rmw

Bit-write emulation stage between the `align` core's SRAM port and a physical 1R1W SRAM macro that has no per-bit write enable. Each masked write from upstream becomes a physical read, a merge with `mem_bw`/`mem_din`, and a physical write SRAM_DELAY cycles later. Forwarding from in-flight merges keeps upstream behaviour identical to a native bit-writable single-port SRAM, with the same read latency.

## Interface
- ROWWDTH, 132, physical row width (NUMWRDS*MEMWDTH of upstream)
- NUMSROW, 256, rows
- BITSROW, 8, row address width
- SRAM_DELAY, 2, physical read latency and upstream read latency; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mem_read  in  1  upstream row read
- mem_write  in  1  upstream masked row write
- mem_addr  in  BITSROW  upstream row address
- mem_bw  in  ROWWDTH  bit-write mask; 1 = take `mem_din` bit
- mem_din  in  ROWWDTH  write data
- mem_dout  out  ROWWDTH  read data, SRAM_DELAY cycles after `mem_read`
- prd  out  1  physical read enable
- prdadr  out  BITSROW  physical read address
- prdout  in  ROWWDTH  physical read data, SRAM_DELAY cycles after `prd`; read-old on same-cycle write to same row
- pwr  out  1  physical write enable
- pwradr  out  BITSROW  physical write address
- pwrdin  out  ROWWDTH  physical full-row write data

## Operation
- Op at cycle s: `mem_read | mem_write`. `prd = mem_read | mem_write` and `prdadr = mem_addr`, both combinational.
- Op pipeline: SRAM_DELAY stages carrying {rd, wr, addr, bw, din}. The op completes at cycle s+D.
- History: D entries {valid, addr, row} holding the physical writes committed in cycles s..s+D-1. These are exactly the writes issued by ops s-D..s-1 that the physical read did not observe.
- Base row at completion: the newest valid history entry whose addr matches the op addr. If none matches, `prdout`.
- Read completion: `mem_dout` = base row.
- Write completion: `pwr = 1`, `pwradr = addr`, `pwrdin = (base & ~bw) | (din & bw)`. Push {1, addr, pwrdin} into history, and drop the oldest entry.
- Cycles with no write completion push an invalid entry into history.
- Read and write in the same cycle: both performed. `mem_dout` returns the pre-write base row.
- Back-to-back writes to one row: each merge sees all earlier merges through forwarding. No stalls, full throughput of one op per cycle.
- `mem_bw = 0` write: the row is rewritten unchanged, and `pwr` still asserts.
- `mem_addr ≥ NUMSROW`: not checked; the address passes through to the macro.

## Timing
- `prd`/`prdadr` are zero-latency from the upstream inputs.
- `mem_dout`, `pwr`, `pwradr`, `pwrdin` are valid at s+D. `pwrdin` is combinational from `prdout` plus the history mux, within the same cycle.
- `mem_dout` is 0 in cycles with no read completion. A write-only completion does not drive `mem_dout`.
- Reset values: `pwr=0`, `pwradr=0`, `pwrdin=0`, `mem_dout=0`, all pipeline valids 0, all history valids 0. `prd`/`prdadr` follow the inputs, gated to 0 while `rst` is high.
- Reset mid-operation: in-flight ops are discarded. No `pwr` is issued for ops accepted before reset. Upstream reads in flight return no data.
- First op after reset deassertion: history is empty, so the base row is `prdout`.

## Structure
- Package `bw_rmw_pkg`: merge function `(base, din, bw)`, and the op-stage struct {rd, wr, addr, bw, din}.
- Sub-module `bw_rmw_hist`: D-deep history shift register with a newest-first address-match lookup. It returns {hit, row}.
- Top level holds the op pipeline, the output muxing and the reset gating.

## Test plan
Configuration: D=2, ROWWDTH=132, with a behavioural 1R1W macro.
- Write row 5, din all-ones, bw = 0x0..0FF; after 4 idle cycles read row 5 → `mem_dout` = old row with bits [7:0]=1, returned at read cycle +2.
- Writes to row 3 in cycles 0, 1, 2 with bw bits [0], [1], [2] and din=all-ones, starting from row=0 → `pwrdin` = 0x1, 0x3, 0x7 at cycles 2, 3, 4 (forwarding at distances 1 and 2).
- Write row 7 at cycle 0, read row 7 at cycle 1 and cycle 2 → both reads return the merged row. A read at cycle 0 alongside the write returns the pre-write row.
- Alternate writes to rows 1 and 2 every cycle for 20 cycles with random bw/din → the macro contents match a reference model. Throughput is one op per cycle.
- Write at cycle 0, `rst` pulse at cycle 1 → no `pwr` in cycles 1–4, all outputs 0 during reset, and the row is unchanged in the macro.
- Write with `mem_bw=0` → `pwr=1`, and `pwrdin` equals the original row.
